// File: rtl/ram_slot_arbiter_if.sv
// Bundle of the CPU, video and SDRAM-controller signals around the slot arbiter.
// The arbiter uses the slave view; requesters and the controller use the master view.
interface ram_slot_arbiter_if;
  logic        slot_start;
  logic        cpu_req;
  logic        cpu_we;
  logic [23:0] cpu_addr;
  logic [1:0]  cpu_ds;
  logic [15:0] cpu_din;
  logic        cpu_ack;
  logic [15:0] cpu_dout;
  logic        vid_req;
  logic [23:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_dout;
  logic        mem_oe;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  modport slave (
    input  slot_start, cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
    input  vid_req, vid_addr, mem_dout,
    output cpu_ack, cpu_dout, vid_ack, vid_dout,
    output mem_oe, mem_we, mem_addr, mem_ds, mem_din
  );

  modport master (
    output slot_start, cpu_req, cpu_we, cpu_addr, cpu_ds, cpu_din,
    output vid_req, vid_addr, mem_dout,
    input  cpu_ack, cpu_dout, vid_ack, vid_dout,
    input  mem_oe, mem_we, mem_addr, mem_ds, mem_din
  );
endinterface

// File: rtl/ram_slot_arbiter.sv
// Slot-based SDRAM arbiter between a CPU port and a video read port.
// Define RAM_SLOT_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise video wins ties.
module ram_slot_arbiter (
  input logic            clk_64,
  input logic            reset,
  ram_slot_arbiter_if.slave bus
);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_CPU, SLOT_VID} slot_t;

  slot_t       state;
  slot_t       state_next;
  logic [2:0]  phase;
  logic        cpu_elig;
  logic        vid_elig;
  logic        done;
  logic        oe_r;
  logic        we_r;
  logic [23:0] addr_r;
  logic [1:0]  ds_r;
  logic [15:0] din_r;
  logic        cpu_ack_r;
  logic        vid_ack_r;
  logic [15:0] cpu_dout_r;
  logic [15:0] vid_dout_r;

`ifdef RAM_SLOT_ARBITER_ROUND_ROBIN_EN
  logic vid_next;

  always_ff @(posedge clk_64) begin
    if (reset) begin
      vid_next <= 1'b0;
    end else if (bus.slot_start && state_next == SLOT_CPU) begin
      vid_next <= 1'b1;
    end else if (bus.slot_start && state_next == SLOT_VID) begin
      vid_next <= 1'b0;
    end
  end
`endif

  // A port acked in the slot_start cycle is excluded so it cannot be served twice in a row.
  always_comb begin
    cpu_elig   = bus.cpu_req & ~cpu_ack_r;
    vid_elig   = bus.vid_req & ~vid_ack_r;
    state_next = state;
    done       = 1'b0;
    if (bus.slot_start) begin
      if (vid_elig && cpu_elig) begin
`ifdef RAM_SLOT_ARBITER_ROUND_ROBIN_EN
        state_next = vid_next ? SLOT_VID : SLOT_CPU;
`else
        state_next = SLOT_VID;
`endif
      end else if (vid_elig) begin
        state_next = SLOT_VID;
      end else if (cpu_elig) begin
        state_next = SLOT_CPU;
      end else begin
        state_next = SLOT_IDLE;
      end
    end else if (phase == 3'd6 && state != SLOT_IDLE) begin
      done = 1'b1;
    end
  end

  always_ff @(posedge clk_64) begin
    if (reset) begin
      state <= SLOT_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_64) begin
    if (reset) begin
      phase <= 3'd7;
    end else if (bus.slot_start) begin
      phase <= 3'd0;
    end else if (phase != 3'd7) begin
      phase <= phase + 3'd1;
    end
  end

  // Command fields change only on slot boundaries and are held for the whole slot.
  always_ff @(posedge clk_64) begin
    if (reset) begin
      oe_r   <= 1'b0;
      we_r   <= 1'b0;
      addr_r <= '0;
      ds_r   <= '0;
      din_r  <= '0;
    end else if (bus.slot_start) begin
      case (state_next)
        SLOT_VID: begin
          oe_r   <= 1'b1;
          we_r   <= 1'b0;
          addr_r <= bus.vid_addr;
          ds_r   <= 2'b11;
          din_r  <= '0;
        end
        SLOT_CPU: begin
          oe_r   <= ~bus.cpu_we;
          we_r   <= bus.cpu_we;
          addr_r <= bus.cpu_addr;
          ds_r   <= bus.cpu_we ? bus.cpu_ds : 2'b11;
          din_r  <= bus.cpu_din;
        end
        default: begin
          oe_r   <= 1'b0;
          we_r   <= 1'b0;
          addr_r <= '0;
          ds_r   <= '0;
          din_r  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_64) begin
    if (reset) begin
      cpu_ack_r  <= 1'b0;
      vid_ack_r  <= 1'b0;
      cpu_dout_r <= '0;
      vid_dout_r <= '0;
    end else begin
      cpu_ack_r <= done && state == SLOT_CPU;
      vid_ack_r <= done && state == SLOT_VID;
      if (done && state == SLOT_VID) begin
        vid_dout_r <= bus.mem_dout;
      end
      if (done && state == SLOT_CPU && !we_r) begin
        cpu_dout_r <= bus.mem_dout;
      end
    end
  end

  assign bus.mem_oe   = oe_r;
  assign bus.mem_we   = we_r;
  assign bus.mem_addr = addr_r;
  assign bus.mem_ds   = ds_r;
  assign bus.mem_din  = din_r;
  assign bus.cpu_ack  = cpu_ack_r;
  assign bus.cpu_dout = cpu_dout_r;
  assign bus.vid_ack  = vid_ack_r;
  assign bus.vid_dout = vid_dout_r;

endmodule
